// File: rtl/beat_pkg.sv
// Shared constants and helpers for the beat/tempo generator.
//   PERIOD_*  : tick periods in clk cycles for a 100 MHz system clock
//   DEF_PERIOD: reset tempo, a 1/32 s beat
//   beat_bw() : width of a beat index for a given beats-per-bar count
package beat_pkg;

    localparam int unsigned PERIOD_1_64S = 1562500;
    localparam int unsigned PERIOD_1_32S = 3125000;
    // 1/16 s needs N >= 23; listed for sequencer configurations built wider.
    localparam int unsigned PERIOD_1_16S = 6250000;
    localparam int unsigned DEF_PERIOD   = PERIOD_1_32S;

    // $clog2 with a floor of 1 so a single-beat bar still has a 1-bit index.
    function automatic int beat_bw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/beat_dff.sv
// Enable register with synchronous active-low reset to a parameter value.
//   clk, reset_n : clock, synchronous active-low reset
//   en           : load d when high, hold otherwise
//   d / q        : W-bit data in / registered out
module beat_dff #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset_n)
            q <= RST;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/beat_prescaler.sv
// N-bit down counter with forced load, hold, and reload-on-zero.
//   load     : force count <= load_val (wins over en)
//   en       : decrement; at zero reload from load_val instead
//   load_val : value loaded on a forced load or a zero reload
//   count    : registered counter value
//   zero     : count == 0 (decoded from the register)
module beat_prescaler #(
    parameter int           N         = 22,
    parameter logic [N-1:0] RST_COUNT = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] count,
    output logic         zero
);

    logic [N-1:0] count_d;

    assign zero = (count == '0);

    // Reload replaces the decrement at zero, so the counter never wraps.
    always_comb begin
        count_d = count - N'(1);
        if (load || zero)
            count_d = load_val;
    end

    beat_dff #(.W(N), .RST(RST_COUNT)) u_cnt (
        .clk(clk), .reset_n(reset_n), .en(load | en), .d(count_d), .q(count)
    );

endmodule

// File: rtl/beat_gen.sv
// Programmable beat/tempo generator.
//   enable    : count when high, hold count/beat_idx when low
//   restart   : reload prescaler from the committed period, clear beat_idx
//   period_we : stage period_in as pending; it commits at next reload/restart
//   tick      : one-cycle pulse every P enabled cycles
//   beat_idx  : beat within the bar, 0..BEATS_PER_BAR-1
//   bar       : pulse with the tick that wraps beat_idx to 0
//   count     : prescaler value, for observation
import beat_pkg::*;

module beat_gen #(
    parameter int N              = 22,
    parameter int DEFAULT_PERIOD = int'(DEF_PERIOD),
    parameter int BEATS_PER_BAR  = 4,
    parameter int BW             = beat_bw(BEATS_PER_BAR)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          restart,
    input  logic          period_we,
    input  logic [N-1:0]  period_in,
    output logic          tick,
    output logic [BW-1:0] beat_idx,
    output logic          bar,
    output logic [N-1:0]  count
);

    localparam logic [N-1:0]  RST_PERIOD = N'(DEFAULT_PERIOD);
    localparam logic [N-1:0]  RST_COUNT  = (DEFAULT_PERIOD <= 1) ? '0 : N'(DEFAULT_PERIOD - 1);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS_PER_BAR - 1);

    logic [N-1:0]  active_period, pending, commit_val, load_val;
    logic          pending_valid, pending_valid_d;
    logic          zero, reload, commit, last;
    logic [BW-1:0] beat_d;

    // Restart outranks enable, so a zero count on a restart edge is not a reload.
    assign reload = enable & zero & ~restart;
    assign commit = restart | reload;

    // The value committed on this edge is the one staged before it; a write
    // landing on the same edge only becomes pending.
    assign commit_val = pending_valid ? pending : active_period;
    assign load_val   = (commit_val <= N'(1)) ? '0 : commit_val - N'(1);

    // A same-edge write keeps pending_valid set even though the old value commits.
    assign pending_valid_d = period_we | (pending_valid & ~commit);

    assign last   = (beat_idx == LAST_BEAT);
    assign beat_d = (restart || last) ? '0 : beat_idx + BW'(1);

    beat_prescaler #(.N(N), .RST_COUNT(RST_COUNT)) u_pre (
        .clk(clk), .reset_n(reset_n), .load(restart), .en(enable),
        .load_val(load_val), .count(count), .zero(zero)
    );

    beat_dff #(.W(N), .RST(RST_PERIOD)) u_active (
        .clk(clk), .reset_n(reset_n), .en(commit & pending_valid),
        .d(pending), .q(active_period)
    );

    beat_dff #(.W(N)) u_pending (
        .clk(clk), .reset_n(reset_n), .en(period_we), .d(period_in), .q(pending)
    );

    beat_dff #(.W(1)) u_pvalid (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .d(pending_valid_d), .q(pending_valid)
    );

    beat_dff #(.W(BW)) u_beat (
        .clk(clk), .reset_n(reset_n), .en(commit), .d(beat_d), .q(beat_idx)
    );

    beat_dff #(.W(1)) u_tick (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .d(reload), .q(tick)
    );

    beat_dff #(.W(1)) u_bar (
        .clk(clk), .reset_n(reset_n), .en(1'b1), .d(reload & last), .q(bar)
    );

endmodule

// File: tb/tb_beat_gen.sv
// Directed bench for beat_gen: N=22, DEFAULT_PERIOD=8, BEATS_PER_BAR=4.
module tb_beat_gen;

    localparam int N   = 22;
    localparam int BPB = 4;
    localparam int BW  = 2;

    logic          clk = 1'b0;
    logic          reset_n, enable, restart, period_we;
    logic [N-1:0]  period_in;
    logic          tick, bar;
    logic [BW-1:0] beat_idx;
    logic [N-1:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    beat_gen #(.N(N), .DEFAULT_PERIOD(8), .BEATS_PER_BAR(BPB), .BW(BW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .restart(restart),
        .period_we(period_we), .period_in(period_in),
        .tick(tick), .beat_idx(beat_idx), .bar(bar), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    cyc;
        logic  rst_n, en, rs, we;
        int    pin;
        logic  e_tick;
        int    e_beat;
        logic  e_bar;
        int    e_count;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input int cyc, input logic rst_n, input logic en,
                       input logic rs, input logic we, input int pin, input logic et,
                       input int eb, input logic ebar, input int ec);
        vec_t v;
        v.name = name; v.cyc = cyc; v.rst_n = rst_n; v.en = en; v.rs = rs; v.we = we;
        v.pin = pin; v.e_tick = et; v.e_beat = eb; v.e_bar = ebar; v.e_count = ec;
        tbl.push_back(v);
    endtask

    // Apply inputs for one rising edge and sample 1 time unit later.
    task automatic step(input logic rst_n, input logic en, input logic rs,
                        input logic we, input int pin);
        reset_n = rst_n; enable = en; restart = rs; period_we = we; period_in = N'(pin);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic et, input int eb,
                       input logic ebar, input int ec);
        n_cmp++;
        if (tick !== et || int'(beat_idx) != eb || bar !== ebar || int'(count) != ec) begin
            n_bad++;
            $display("FAIL %s: got tick=%0b beat=%0d bar=%0b count=%0d, want tick=%0b beat=%0d bar=%0b count=%0d",
                     name, tick, beat_idx, bar, count, et, eb, ebar, ec);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; restart = 1'b0; period_we = 1'b0; period_in = '0;

        // Free run at default period 8: ticks at edges 8,16,24,32, bar at 32.
        //   name          cyc rst en rs we pin  tick beat bar count
        add("reset",        1, 0, 0, 0, 0, 0,   0,   0,  0,  7);
        add("run_e1",       1, 1, 1, 0, 0, 0,   0,   0,  0,  6);
        add("run_e7",       6, 1, 1, 0, 0, 0,   0,   0,  0,  0);
        add("run_e8",       1, 1, 1, 0, 0, 0,   1,   1,  0,  7);
        add("run_e9",       1, 1, 1, 0, 0, 0,   0,   1,  0,  6);
        add("run_e16",      7, 1, 1, 0, 0, 0,   1,   2,  0,  7);
        add("run_e24",      8, 1, 1, 0, 0, 0,   1,   3,  0,  7);
        add("run_e31",      7, 1, 1, 0, 0, 0,   0,   3,  0,  0);
        add("run_e32_bar",  1, 1, 1, 0, 0, 0,   1,   0,  1,  7);
        add("run_e33",      1, 1, 1, 0, 0, 0,   0,   0,  0,  6);
        // Period write of 3 at edge 2: tick still at 8, then 11,14,17.
        add("wr_reset",     1, 0, 0, 0, 0, 0,   0,   0,  0,  7);
        add("wr_e1",        1, 1, 1, 0, 0, 0,   0,   0,  0,  6);
        add("wr_e2_we3",    1, 1, 1, 0, 1, 3,   0,   0,  0,  5);
        add("wr_e7",        5, 1, 1, 0, 0, 0,   0,   0,  0,  0);
        add("wr_e8_commit", 1, 1, 1, 0, 0, 0,   1,   1,  0,  2);
        add("wr_e10",       2, 1, 1, 0, 0, 0,   0,   1,  0,  0);
        add("wr_e11",       1, 1, 1, 0, 0, 0,   1,   2,  0,  2);
        add("wr_e14",       3, 1, 1, 0, 0, 0,   1,   3,  0,  2);
        add("wr_e17_bar",   3, 1, 1, 0, 0, 0,   1,   0,  1,  2);
        // Write landing on a reload edge does not affect that reload.
        add("wr_e19",       2, 1, 1, 0, 0, 0,   0,   0,  0,  0);
        add("wr_e20_onrl",  1, 1, 1, 0, 1, 5,   1,   1,  0,  2);
        add("wr_e22",       2, 1, 1, 0, 0, 0,   0,   1,  0,  0);
        add("wr_e23_p5",    1, 1, 1, 0, 0, 0,   1,   2,  0,  4);

        foreach (tbl[i]) begin
            for (int c = 0; c < tbl[i].cyc; c++)
                step(tbl[i].rst_n, tbl[i].en, tbl[i].rs, tbl[i].we, tbl[i].pin);
            chk(tbl[i].name, tbl[i].e_tick, tbl[i].e_beat, tbl[i].e_bar, tbl[i].e_count);
        end

        // Pause 5 cycles at count=4: tick slips from edge 8 to edge 13.
        step(0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) step(1, 1, 0, 0, 0);
        chk("pause_pre", 0, 0, 0, 4);
        for (int c = 0; c < 5; c++) begin
            step(1, 0, 0, 0, 0);
            chk("pause_hold", 0, 0, 0, 4);
        end
        for (int c = 0; c < 4; c++) step(1, 1, 0, 0, 0);
        chk("pause_e12", 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("pause_e13_tick", 1, 1, 0, 7);

        // Restart at count=3, beat=2 with pending period 5.
        step(0, 0, 0, 0, 0);
        for (int c = 0; c < 17; c++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 5);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("rs_pre", 0, 2, 0, 3);
        step(1, 1, 1, 0, 0);
        chk("rs_edge", 0, 0, 0, 4);
        for (int c = 0; c < 4; c++) step(1, 1, 0, 0, 0);
        chk("rs_e4", 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("rs_e5_tick", 1, 1, 0, 4);
        // Restart while disabled still reloads and clears.
        step(1, 0, 1, 0, 0);
        chk("rs_disabled", 0, 0, 0, 4);

        // Periods 0 and 1 give a tick every enabled cycle.
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        chk("p0_restart", 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(1, 1, 0, 0, 0);
            chk("p0_run", 1, k % BPB, (k == 4), 0);
        end
        step(1, 0, 0, 1, 1);
        chk("p1_write_paused", 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("p1_restart", 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(1, 1, 0, 0, 0);
            chk("p1_run", 1, k % BPB, (k == 4), 0);
        end
        // Write on a restart edge is only staged; the next reload commits it.
        step(1, 1, 1, 1, 6);
        chk("rs_we_same", 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("rs_we_commit", 1, 1, 0, 5);

        // Reset mid-count discards a pending write; period stays 8.
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 3);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("rst_mid", 0, 0, 0, 7);
        for (int c = 0; c < 7; c++) step(1, 1, 0, 0, 0);
        chk("rst_mid_e7", 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("rst_mid_e8", 1, 1, 0, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
